// File: rtl/aria_pkg.sv
// Shared ARIA key-schedule definitions: round constants, key length encoding and
// the Feistel initialisation state encoding.
package aria_pkg;

  localparam int unsigned ARIA_BLK_W = 128;

  localparam logic [127:0] C1 = 128'h517cc1b727220a94fe13abe8fa9a6ee0;
  localparam logic [127:0] C2 = 128'h6db14acc9e21c820ff28b1d5ef5de2b0;
  localparam logic [127:0] C3 = 128'hdb92371d2126e9700324977504e8c90e;

  typedef enum logic [1:0] {
    KLEN_128 = 2'd0,
    KLEN_192 = 2'd1,
    KLEN_256 = 2'd2,
    KLEN_BAD = 2'd3
  } key_len_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R1,
    ST_R2,
    ST_R3,
    ST_DONE
  } state_t;

endpackage

// File: rtl/aria_ck_sel.sv
// Combinational key-length decode: splits the key into KL/KR (KR masked to the
// real key length) and selects the rotated round-constant triple.
module aria_ck_sel
  import aria_pkg::*;
#(
  parameter int unsigned KEY_W = 256
) (
  input  logic [1:0]            key_len,
  input  logic [KEY_W-1:0]      key,
  output logic [ARIA_BLK_W-1:0] kl,
  output logic [ARIA_BLK_W-1:0] kr,
  output logic [ARIA_BLK_W-1:0] ck1,
  output logic [ARIA_BLK_W-1:0] ck2,
  output logic [ARIA_BLK_W-1:0] ck3
);

  always_comb begin
    kl  = key[KEY_W-1 -: ARIA_BLK_W];
    kr  = '0;
    ck1 = C1;
    ck2 = C2;
    ck3 = C3;
    case (key_len)
      KLEN_192: begin
        kr[127:64] = key[KEY_W-129 -: 64];
        ck1 = C2;
        ck2 = C3;
        ck3 = C1;
      end
      KLEN_256: begin
        kr  = key[KEY_W-129 -: ARIA_BLK_W];
        ck1 = C3;
        ck2 = C1;
        ck3 = C2;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/aria_key_expand.sv
// ARIA key extension: 3-round Feistel initialisation producing W0..W3 through a
// shared external round-function unit. Optional key_clear port: ARIA_KEY_ZEROIZE_EN.
module aria_key_expand
  import aria_pkg::*;
#(
  parameter int unsigned BLK_W = ARIA_BLK_W,
  parameter int unsigned KEY_W = 256
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef ARIA_KEY_ZEROIZE_EN
  input  logic             key_clear,
`endif
  input  logic [KEY_W-1:0] key,
  input  logic [1:0]       key_len,
  input  logic             key_start,
  output logic             busy,
  output logic             w_valid,
  output logic             key_err,
  output logic [BLK_W-1:0] w0,
  output logic [BLK_W-1:0] w1,
  output logic [BLK_W-1:0] w2,
  output logic [BLK_W-1:0] w3,
  output logic             fn_req,
  output logic             fn_odd,
  output logic [BLK_W-1:0] fn_din,
  output logic [BLK_W-1:0] fn_ck,
  input  logic             fn_ack,
  input  logic [BLK_W-1:0] fn_dout
);

  if (BLK_W != 128) begin : g_blk_w_check
    $error("aria_key_expand: BLK_W must be 128");
  end

  state_t           state, state_n;
  logic [BLK_W-1:0] kr_q, ck1_q, ck2_q, ck3_q;
  logic [BLK_W-1:0] kr_n, ck1_n, ck2_n, ck3_n;
  logic [BLK_W-1:0] w0_n, w1_n, w2_n, w3_n;
  logic [BLK_W-1:0] fn_din_n, fn_ck_n;
  logic             fn_req_n, fn_odd_n, w_valid_n, key_err_n;
  logic [BLK_W-1:0] sel_kl, sel_kr, sel_ck1, sel_ck2, sel_ck3;
  logic             ack;
  logic [BLK_W-1:0] rnd_out;

  aria_ck_sel #(.KEY_W(KEY_W)) u_ck_sel (
    .key_len (key_len),
    .key     (key),
    .kl      (sel_kl),
    .kr      (sel_kr),
    .ck1     (sel_ck1),
    .ck2     (sel_ck2),
    .ck3     (sel_ck3)
  );

  assign busy = (state == ST_R1) || (state == ST_R2) || (state == ST_R3);
  // An ack only counts against a request actually on the wire.
  assign ack  = fn_req & fn_ack;

  always_comb begin
    state_n   = state;
    kr_n      = kr_q;
    ck1_n     = ck1_q;
    ck2_n     = ck2_q;
    ck3_n     = ck3_q;
    w0_n      = w0;
    w1_n      = w1;
    w2_n      = w2;
    w3_n      = w3;
    fn_req_n  = fn_req;
    fn_odd_n  = fn_odd;
    fn_din_n  = fn_din;
    fn_ck_n   = fn_ck;
    w_valid_n = w_valid;
    key_err_n = 1'b0;
    rnd_out   = '0;

    case (state)
      ST_IDLE, ST_DONE: begin
        if (key_start) begin
          if (key_len == KLEN_BAD) begin
            key_err_n = 1'b1;
          end else begin
            state_n   = ST_R1;
            w0_n      = sel_kl;
            kr_n      = sel_kr;
            ck1_n     = sel_ck1;
            ck2_n     = sel_ck2;
            ck3_n     = sel_ck3;
            w_valid_n = 1'b0;
          end
        end
      end
      ST_R1: begin
        // First R1 cycle issues the request once w0 is registered.
        if (!fn_req) begin
          fn_req_n = 1'b1;
          fn_odd_n = 1'b1;
          fn_din_n = w0;
          fn_ck_n  = ck1_q;
        end else if (ack) begin
          rnd_out  = fn_dout ^ kr_q;
          w1_n     = rnd_out;
          fn_odd_n = 1'b0;
          fn_din_n = rnd_out;
          fn_ck_n  = ck2_q;
          state_n  = ST_R2;
        end
      end
      ST_R2: begin
        if (ack) begin
          rnd_out  = fn_dout ^ w0;
          w2_n     = rnd_out;
          fn_odd_n = 1'b1;
          fn_din_n = rnd_out;
          fn_ck_n  = ck3_q;
          state_n  = ST_R3;
        end
      end
      ST_R3: begin
        if (ack) begin
          w3_n      = fn_dout ^ w1;
          fn_req_n  = 1'b0;
          fn_odd_n  = 1'b0;
          w_valid_n = 1'b1;
          state_n   = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

`ifdef ARIA_KEY_ZEROIZE_EN
    if (key_clear) begin
      state_n   = ST_IDLE;
      w0_n      = '0;
      w1_n      = '0;
      w2_n      = '0;
      w3_n      = '0;
      fn_req_n  = 1'b0;
      fn_odd_n  = 1'b0;
      w_valid_n = 1'b0;
      key_err_n = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      kr_q    <= '0;
      ck1_q   <= '0;
      ck2_q   <= '0;
      ck3_q   <= '0;
      w0      <= '0;
      w1      <= '0;
      w2      <= '0;
      w3      <= '0;
      fn_req  <= 1'b0;
      fn_odd  <= 1'b0;
      fn_din  <= '0;
      fn_ck   <= '0;
      w_valid <= 1'b0;
      key_err <= 1'b0;
    end else begin
      state   <= state_n;
      kr_q    <= kr_n;
      ck1_q   <= ck1_n;
      ck2_q   <= ck2_n;
      ck3_q   <= ck3_n;
      w0      <= w0_n;
      w1      <= w1_n;
      w2      <= w2_n;
      w3      <= w3_n;
      fn_req  <= fn_req_n;
      fn_odd  <= fn_odd_n;
      fn_din  <= fn_din_n;
      fn_ck   <= fn_ck_n;
      w_valid <= w_valid_n;
      key_err <= key_err_n;
    end
  end

endmodule

// File: tb/tb_aria_key_expand.sv
// Self-checking bench for aria_key_expand with a d^ck round-function stub and a
// behavioural key-extension model. Exercises key_clear when ARIA_KEY_ZEROIZE_EN is defined.
module tb_aria_key_expand;

  localparam logic [127:0] K_C1 = 128'h517cc1b727220a94fe13abe8fa9a6ee0;
  localparam logic [127:0] K_C2 = 128'h6db14acc9e21c820ff28b1d5ef5de2b0;
  localparam logic [127:0] K_C3 = 128'hdb92371d2126e9700324977504e8c90e;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] key = '0;
  logic [1:0]   key_len = 2'd0;
  logic         key_start = 1'b0;
  logic         busy, w_valid, key_err, fn_req, fn_odd, fn_ack;
  logic [127:0] w0, w1, w2, w3, fn_din, fn_ck, fn_dout;
`ifdef ARIA_KEY_ZEROIZE_EN
  logic         key_clear = 1'b0;
`endif

  always #5 clk = ~clk;

  aria_key_expand #(.BLK_W(128), .KEY_W(256)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef ARIA_KEY_ZEROIZE_EN
    .key_clear (key_clear),
`endif
    .key       (key),
    .key_len   (key_len),
    .key_start (key_start),
    .busy      (busy),
    .w_valid   (w_valid),
    .key_err   (key_err),
    .w0        (w0),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .fn_req    (fn_req),
    .fn_odd    (fn_odd),
    .fn_din    (fn_din),
    .fn_ck     (fn_ck),
    .fn_ack    (fn_ack),
    .fn_dout   (fn_dout)
  );

  // Round-function stub: F(d,ck) = d ^ ck, ack after a configurable delay.
  int           dly_mode = -1;
  int           cnt = 0;
  bit           stub_en = 1'b1;
  logic         ack_stub = 1'b0;
  logic         force_ack = 1'b0;
  logic [127:0] ck_log[$];
  logic         odd_log[$];

  assign fn_dout = fn_din ^ fn_ck;
  assign fn_ack  = force_ack | (stub_en & ack_stub);

  always @(negedge clk) begin
    ack_stub = 1'b0;
    if (stub_en && fn_req === 1'b1) begin
      if (cnt <= 0) begin
        ack_stub = 1'b1;
        ck_log.push_back(fn_ck);
        odd_log.push_back(fn_odd);
        cnt = (dly_mode < 0) ? int'($urandom_range(0, 3)) : dly_mode;
      end else begin
        cnt--;
      end
    end
  end

  int           checks = 0;
  int           failures = 0;
  logic [127:0] e_w[4];
  logic [127:0] e_ck[3];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: KR masked to key length, constants rotated by key length.
  task automatic model(input logic [255:0] k, input int len);
    logic [127:0] tab[3];
    logic [127:0] kr;
    tab = '{K_C1, K_C2, K_C3};
    kr = '0;
    if (len == 1) kr = {k[127:64], 64'h0};
    if (len == 2) kr = k[127:0];
    for (int i = 0; i < 3; i++) e_ck[i] = tab[(len + i) % 3];
    e_w[0] = k[255:128];
    e_w[1] = (e_w[0] ^ e_ck[0]) ^ kr;
    e_w[2] = (e_w[1] ^ e_ck[1]) ^ e_w[0];
    e_w[3] = (e_w[2] ^ e_ck[2]) ^ e_w[1];
  endtask

  task automatic chk_words(input string tag);
    chk({tag, ".w0"}, w0, e_w[0]);
    chk({tag, ".w1"}, w1, e_w[1]);
    chk({tag, ".w2"}, w2, e_w[2]);
    chk({tag, ".w3"}, w3, e_w[3]);
  endtask

  task automatic start(input logic [255:0] k, input logic [1:0] len);
    @(negedge clk);
    key = k;
    key_len = len;
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && w_valid !== 1'b1; i++) @(negedge clk);
    chk({tag, ".w_valid"}, w_valid, 1);
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int i = 0; i < 8; i++) k[i*32 +: 32] = $urandom;
    return k;
  endfunction

  logic [255:0] k1;
  int           ln;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.busy", busy, 0);
    chk("rst.w_valid", w_valid, 0);
    chk("rst.key_err", key_err, 0);
    chk("rst.fn_req", fn_req, 0);
    chk("rst.fn_odd", fn_odd, 0);
    chk("rst.w3", w3, 0);
    chk("rst.fn_ck", fn_ck, 0);
    rst_n = 1'b1;

    // 1: zero key, len 128, same-cycle ack, latency
    dly_mode = 0;
    cnt = 0;
    model('0, 0);
    start('0, 2'd0);
    chk("t1.busy", busy, 1);
    repeat (3) @(negedge clk);
    chk("t1.w_valid_early", w_valid, 0);
    @(negedge clk);
    chk("t1.w_valid_lat", w_valid, 1);
    chk("t1.busy_done", busy, 0);
    chk("t1.w1_c1", w1, K_C1);
    chk("t1.w3_c2c3", w3, K_C2 ^ K_C3);
    chk_words("t1");

    // 2: all-ones key, len 192, constant order and Fo/Fe order
    dly_mode = -1;
    ck_log.delete();
    odd_log.delete();
    model('1, 1);
    start('1, 2'd1);
    wait_valid("t2");
    chk_words("t2");
    chk("t2.req_count", 128'(ck_log.size()), 3);
    for (int i = 0; i < 3 && i < ck_log.size(); i++) begin
      chk($sformatf("t2.ck%0d", i + 1), ck_log[i], e_ck[i]);
      chk($sformatf("t2.odd%0d", i + 1), odd_log[i], (i != 1));
    end
    chk("t2.ck1_is_c2", e_ck[0], K_C2);

    // 3: len 256, re-pulse while busy is ignored
    k1 = rand_key();
    model(k1, 2);
    start(k1, 2'd2);
    @(negedge clk);
    chk("t3.busy", busy, 1);
    key = rand_key();
    key_len = 2'd0;
    key_start = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    chk("t3.no_err", key_err, 0);
    wait_valid("t3");
    chk_words("t3");

    // 4: illegal length in DONE
    start(rand_key(), 2'd3);
    chk("t4.key_err", key_err, 1);
    chk("t4.w_valid", w_valid, 1);
    chk("t4.busy", busy, 0);
    @(negedge clk);
    chk("t4.key_err_pulse", key_err, 0);
    chk_words("t4");

    // Random keys and lengths
    for (int n = 0; n < 6; n++) begin
      k1 = rand_key();
      ln = int'($urandom_range(0, 2));
      model(k1, ln);
      start(k1, 2'(ln));
      @(negedge clk);
      chk($sformatf("rnd%0d.w_valid_drop", n), w_valid, 0);
      wait_valid($sformatf("rnd%0d", n));
      chk_words($sformatf("rnd%0d", n));
    end

    // 5: reset during R2 with pending request; late ack ignored
    dly_mode = 3;
    start(rand_key(), 2'd2);
    for (int i = 0; i < 40 && !(fn_req === 1'b1 && fn_odd === 1'b0); i++) @(negedge clk);
    chk("t5.in_r2", {fn_req, fn_odd}, 2'b10);
    rst_n = 1'b0;
    stub_en = 1'b0;
    @(negedge clk);
    chk("t5.fn_req", fn_req, 0);
    chk("t5.busy", busy, 0);
    chk("t5.w_valid", w_valid, 0);
    chk("t5.w0", w0, 0);
    chk("t5.w1", w1, 0);
    chk("t5.fn_din", fn_din, 0);
    chk("t5.fn_ck", fn_ck, 0);
    rst_n = 1'b1;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    chk("t5.late_busy", busy, 0);
    chk("t5.late_req", fn_req, 0);
    chk("t5.late_w1", w1, 0);
    stub_en = 1'b1;
    dly_mode = -1;

`ifdef ARIA_KEY_ZEROIZE_EN
    // 6: zeroize in DONE, then zeroize racing a start
    k1 = rand_key();
    model(k1, 0);
    start(k1, 2'd0);
    wait_valid("t6a");
    chk_words("t6a");
    @(negedge clk);
    key_clear = 1'b1;
    @(negedge clk);
    key_clear = 1'b0;
    chk("t6.w0", w0, 0);
    chk("t6.w1", w1, 0);
    chk("t6.w2", w2, 0);
    chk("t6.w3", w3, 0);
    chk("t6.w_valid", w_valid, 0);
    @(negedge clk);
    key = rand_key();
    key_len = 2'd1;
    key_start = 1'b1;
    key_clear = 1'b1;
    @(negedge clk);
    key_start = 1'b0;
    key_clear = 1'b0;
    chk("t6.race_busy", busy, 0);
    chk("t6.race_w0", w0, 0);
    @(negedge clk);
    chk("t6.race_idle", busy, 0);
    chk("t6.race_req", fn_req, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
